// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding, IR field
// positions, ISA opcodes, ALU operation codes and the opcode-to-ALU-op table.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
    } state_e;

    localparam int unsigned OpMsb = 31;
    localparam int unsigned OpLsb = 27;
    localparam int unsigned RaMsb = 26;
    localparam int unsigned RaLsb = 23;
    localparam int unsigned RbMsb = 22;
    localparam int unsigned RbLsb = 19;
    localparam int unsigned RcMsb = 18;
    localparam int unsigned RcLsb = 15;

    localparam logic [4:0] OpcAdd  = 5'b00011;
    localparam logic [4:0] OpcSub  = 5'b00100;
    localparam logic [4:0] OpcAnd  = 5'b00101;
    localparam logic [4:0] OpcOr   = 5'b00110;
    localparam logic [4:0] OpcShr  = 5'b00111;
    localparam logic [4:0] OpcShra = 5'b01000;
    localparam logic [4:0] OpcShl  = 5'b01001;
    localparam logic [4:0] OpcRor  = 5'b01010;
    localparam logic [4:0] OpcRol  = 5'b01011;
    localparam logic [4:0] OpcMul  = 5'b01111;
    localparam logic [4:0] OpcDiv  = 5'b10000;
    localparam logic [4:0] OpcNeg  = 5'b10001;
    localparam logic [4:0] OpcNot  = 5'b10010;
    localparam logic [4:0] OpcNop  = 5'b11010;
    localparam logic [4:0] OpcHalt = 5'b11011;

    localparam logic [4:0] AluAdd  = 5'b00011;
    localparam logic [4:0] AluSub  = 5'b00100;
    localparam logic [4:0] AluAnd  = 5'b00101;
    localparam logic [4:0] AluOr   = 5'b00110;
    localparam logic [4:0] AluShr  = 5'b01000;
    localparam logic [4:0] AluShra = 5'b01001;
    localparam logic [4:0] AluShl  = 5'b01010;
    localparam logic [4:0] AluRor  = 5'b01011;
    localparam logic [4:0] AluRol  = 5'b01100;
    localparam logic [4:0] AluMul  = 5'b01111;
    localparam logic [4:0] AluDiv  = 5'b10000;
    localparam logic [4:0] AluNeg  = 5'b10001;
    localparam logic [4:0] AluNot  = 5'b10010;

    typedef struct packed {
        logic       valid;
        logic [4:0] op;
    } alu_map_t;

    // valid=0 marks opcodes with no execute phase (NOP, HALT, unlisted)
    function automatic alu_map_t op_map(input logic [4:0] opc);
        alu_map_t m;
        m.valid = 1'b1;
        m.op    = '0;
        case (opc)
            OpcAdd:  m.op = AluAdd;
            OpcSub:  m.op = AluSub;
            OpcAnd:  m.op = AluAnd;
            OpcOr:   m.op = AluOr;
            OpcShr:  m.op = AluShr;
            OpcShra: m.op = AluShra;
            OpcShl:  m.op = AluShl;
            OpcRor:  m.op = AluRor;
            OpcRol:  m.op = AluRol;
            OpcMul:  m.op = AluMul;
            OpcDiv:  m.op = AluDiv;
            OpcNeg:  m.op = AluNeg;
            OpcNot:  m.op = AluNot;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/control_sequencer_reg_sel_decoder.sv
// Register-select decoder: 4-bit IR register field plus enable to a one-hot bus.
module control_sequencer_reg_sel_decoder #(
    parameter int unsigned NREG = 16
) (
    input  logic [3:0]      field_i,
    input  logic            en_i,
    output logic [NREG-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[field_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) and R-format execute (T3-T6) strobes.
// Define CU_ILLEGAL_TRAP_EN to halt on unlisted opcodes and expose the Illegal flag.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned NREG = 16,
    parameter int unsigned OPW  = 5
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic [31:0]     IR,
    input  logic            Stop,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            ZLowin,
    output logic            ZHighin,
    output logic            ZLowout,
    output logic            ZHighout,
    output logic            HIin,
    output logic            LOin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [OPW-1:0]  OP,
    output logic            Run,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic            Illegal,
`endif
    output logic            InstrDone
);

    state_e   state_q, state_d;
    alu_map_t amap;
    logic [4:0] opc;
    logic is_muldiv, is_unary, is_nop, is_halt;
    logic rin_en, rb_en, rc_en;
    logic [NREG-1:0] rout_b, rout_c;
    logic unused_ir;

    assign opc       = IR[OpMsb:OpLsb];
    assign amap      = op_map(opc);
    assign is_muldiv = (opc == OpcMul) || (opc == OpcDiv);
    assign is_unary  = (opc == OpcNeg) || (opc == OpcNot);
    assign is_nop    = (opc == OpcNop);
    assign is_halt   = (opc == OpcHalt);
    assign unused_ir = ^IR[RcLsb-1:0];

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign Illegal = illegal_q;
`endif

    always_comb begin
        state_d = state_q;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            StReset: state_d = StT0;
            StT0:    state_d = StT1;
            StT1:    state_d = StT2;
            // IR must already carry the fetched opcode late in T2 for the NOP/HALT branch
            StT2: begin
                if (is_halt) begin
                    state_d = StHalt;
                end else if (amap.valid) begin
                    state_d = StT3;
                end else begin
`ifdef CU_ILLEGAL_TRAP_EN
                    if (is_nop) begin
                        state_d = StT0;
                    end else begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
`else
                    state_d = StT0;
`endif
                end
            end
            StT3:    state_d = StT4;
            StT4:    state_d = StT5;
            StT5:    state_d = is_muldiv ? StT6 : StT0;
            StT6:    state_d = StT0;
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
        if ((state_d == StT0) && Stop) begin
            state_d = StHalt;
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= StReset;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign rin_en = (state_q == StT5) && !is_muldiv;
    assign rb_en  = (state_q == StT3);
    assign rc_en  = (state_q == StT4) && !is_unary;

    control_sequencer_reg_sel_decoder #(.NREG(NREG)) u_ra_dec (
        .field_i  (IR[RaMsb:RaLsb]),
        .en_i     (rin_en),
        .onehot_o (Rin)
    );

    control_sequencer_reg_sel_decoder #(.NREG(NREG)) u_rb_dec (
        .field_i  (IR[RbMsb:RbLsb]),
        .en_i     (rb_en),
        .onehot_o (rout_b)
    );

    control_sequencer_reg_sel_decoder #(.NREG(NREG)) u_rc_dec (
        .field_i  (IR[RcMsb:RcLsb]),
        .en_i     (rc_en),
        .onehot_o (rout_c)
    );

    // rb_en and rc_en are never both high, so the OR stays one-hot
    assign Rout = rout_b | rout_c;

    always_comb begin
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ZLowin    = 1'b0;
        ZHighin   = 1'b0;
        ZLowout   = 1'b0;
        ZHighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        OP        = '0;
        InstrDone = 1'b0;
        Run       = (state_q != StReset) && (state_q != StHalt);
        unique case (state_q)
            StT0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowin = 1'b1;
            end
            StT1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
                InstrDone = is_nop;
`else
                InstrDone = !amap.valid && !is_halt;
`endif
            end
            StT3: Yin = 1'b1;
            StT4: begin
                OP      = OPW'(amap.op);
                ZLowin  = 1'b1;
                ZHighin = 1'b1;
            end
            StT5: begin
                ZLowout   = 1'b1;
                LOin      = is_muldiv;
                InstrDone = !is_muldiv;
            end
            StT6: begin
                ZHighout  = 1'b1;
                HIin      = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer; honours CU_ILLEGAL_TRAP_EN.
module tb_control_sequencer;

    localparam logic [14:0] S_PCOUT    = 15'h4000;
    localparam logic [14:0] S_PCIN     = 15'h2000;
    localparam logic [14:0] S_INCPC    = 15'h1000;
    localparam logic [14:0] S_MARIN    = 15'h0800;
    localparam logic [14:0] S_READ     = 15'h0400;
    localparam logic [14:0] S_MDRIN    = 15'h0200;
    localparam logic [14:0] S_MDROUT   = 15'h0100;
    localparam logic [14:0] S_IRIN     = 15'h0080;
    localparam logic [14:0] S_YIN      = 15'h0040;
    localparam logic [14:0] S_ZLOWIN   = 15'h0020;
    localparam logic [14:0] S_ZHIGHIN  = 15'h0010;
    localparam logic [14:0] S_ZLOWOUT  = 15'h0008;
    localparam logic [14:0] S_ZHIGHOUT = 15'h0004;
    localparam logic [14:0] S_HIIN     = 15'h0002;
    localparam logic [14:0] S_LOIN     = 15'h0001;

    localparam logic [14:0] F0 = S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN;
    localparam logic [14:0] F1 = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
    localparam logic [14:0] F2 = S_MDROUT | S_IRIN;
    localparam logic [14:0] E4 = S_ZLOWIN | S_ZHIGHIN;
    localparam logic [14:0] M5 = S_ZLOWOUT | S_LOIN;
    localparam logic [14:0] M6 = S_ZHIGHOUT | S_HIIN;

    typedef struct {
        logic [31:0] ir;
        logic        stop;
        logic [14:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
        logic        run;
        logic        done;
        logic        ill;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        Stop;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
    logic ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, Run, InstrDone;
    logic [15:0] Rin, Rout;
    logic [4:0]  OP;
    logic        act_ill;
    logic [14:0] act_strb;

    int nvec = 0;
    int nerr = 0;
    vec_t tbl[$];

    always #5 Clock = ~Clock;

    control_sequencer #(.NREG(16), .OPW(5)) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .IR        (IR),
        .Stop      (Stop),
        .PCout     (PCout),
        .PCin      (PCin),
        .IncPC     (IncPC),
        .MARin     (MARin),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .ZLowin    (ZLowin),
        .ZHighin   (ZHighin),
        .ZLowout   (ZLowout),
        .ZHighout  (ZHighout),
        .HIin      (HIin),
        .LOin      (LOin),
        .Rin       (Rin),
        .Rout      (Rout),
        .OP        (OP),
        .Run       (Run),
`ifdef CU_ILLEGAL_TRAP_EN
        .Illegal   (act_ill),
`endif
        .InstrDone (InstrDone)
    );

`ifndef CU_ILLEGAL_TRAP_EN
    assign act_ill = 1'b0;
`endif

    assign act_strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
                       ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin};

    function automatic vec_t mk(input logic [31:0] ir, input logic stop,
                                input logic [14:0] strb, input logic [15:0] rin,
                                input logic [15:0] rout, input logic [4:0] op,
                                input logic run, input logic done, input logic ill);
        vec_t v;
        v.ir = ir; v.stop = stop; v.strb = strb; v.rin = rin; v.rout = rout;
        v.op = op; v.run = run; v.done = done; v.ill = ill;
        return v;
    endfunction

    task automatic push_fetch(input logic [31:0] ir, input logic t2_done);
        tbl.push_back(mk(ir, 1'b0, F0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(ir, 1'b0, F1, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(ir, 1'b0, F2, 16'h0, 16'h0, 5'b0, 1'b1, t2_done, 1'b0));
    endtask

    task automatic push_alu(input logic [31:0] ir, input logic [15:0] rb,
                            input logic [15:0] rc, input logic [4:0] op,
                            input logic [15:0] ra);
        push_fetch(ir, 1'b0);
        tbl.push_back(mk(ir, 1'b0, S_YIN, 16'h0, rb, 5'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(ir, 1'b0, E4, 16'h0, rc, op, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(ir, 1'b0, S_ZLOWOUT, ra, 16'h0, 5'b0, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic push_muldiv(input logic [31:0] ir, input logic [15:0] rb,
                               input logic [15:0] rc, input logic [4:0] op);
        push_fetch(ir, 1'b0);
        tbl.push_back(mk(ir, 1'b0, S_YIN, 16'h0, rb, 5'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(ir, 1'b0, E4, 16'h0, rc, op, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(ir, 1'b0, M5, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(ir, 1'b0, M6, 16'h0, 16'h0, 5'b0, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic check(input string tag, input vec_t v);
        nvec++;
        if (act_strb !== v.strb || Rin !== v.rin || Rout !== v.rout || OP !== v.op ||
            Run !== v.run || InstrDone !== v.done || act_ill !== v.ill) begin
            nerr++;
            $display("FAIL %s: got strb=%h rin=%h rout=%h op=%b run=%b done=%b ill=%b, want strb=%h rin=%h rout=%h op=%b run=%b done=%b ill=%b",
                     tag, act_strb, Rin, Rout, OP, Run, InstrDone, act_ill,
                     v.strb, v.rin, v.rout, v.op, v.run, v.done, v.ill);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(posedge Clock);
        #1;
        IR   = v.ir;
        Stop = v.stop;
        @(negedge Clock);
        check(tag, v);
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        #2;
        Clear = 1'b0;
    endtask

    vec_t zero_v, halt_v;

    initial begin
        zero_v = mk(32'h0, 1'b0, 15'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 1'b0);

        push_alu(32'h389A8000, 16'h0008, 16'h0020, 5'b01000, 16'h0002);  // SHR R1,R3,R5
        push_muldiv(32'h79188000, 16'h0008, 16'h0002, 5'b01111);         // MUL R3,R1
        push_alu(32'h91200000, 16'h0010, 16'h0000, 5'b10010, 16'h0004);  // NOT R2,R4
        push_fetch(32'hD0000000, 1'b1);                                  // NOP
        push_alu(32'h18000000, 16'h0001, 16'h0001, 5'b00011, 16'h0001);  // ADD R0,R0,R0
        push_alu(32'h4FF68000, 16'h4000, 16'h2000, 5'b01010, 16'h8000);  // SHL R15,R14,R13
        push_alu(32'h89B80000, 16'h0080, 16'h0000, 5'b10001, 16'h0008);  // NEG R3,R7
        push_alu(32'h5A2B0000, 16'h0020, 16'h0040, 5'b01100, 16'h0010);  // ROL R4,R5,R6
        push_muldiv(32'h80918000, 16'h0004, 16'h0008, 5'b10000);         // DIV R2,R3

        Clear = 1'b1;
        IR    = 32'h0;
        Stop  = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset", zero_v);
        Clear = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Clear asserted in the middle of T4 of an ADD
        tbl.delete();
        push_alu(32'h18000000, 16'h0001, 16'h0001, 5'b00011, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("clr_pre[%0d]", i), tbl[i]);
        end
        Clear = 1'b1;
        #1;
        check("clr_async", zero_v);
        @(posedge Clock);
        #1;
        check("clr_hold", zero_v);
        @(negedge Clock);
        Clear = 1'b0;

        // HALT instruction: absorbing, then Clear restarts at T0
        halt_v = mk(32'hD8000000, 1'b0, 15'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 1'b0);
        tbl.delete();
        push_fetch(32'hD8000000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("halt_fetch[%0d]", i), tbl[i]);
        end
        for (int i = 0; i < 20; i++) begin
            apply($sformatf("halt_hold[%0d]", i), halt_v);
        end
        pulse_clear();

        // Stop raised in T3 of ADD R6,R1,R2: instruction completes, then HALT
        tbl.delete();
        push_alu(32'h1B090000, 16'h0002, 16'h0004, 5'b00011, 16'h0040);
        tbl[3].stop = 1'b1;
        tbl[4].stop = 1'b1;
        tbl[5].stop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply($sformatf("stop[%0d]", i), tbl[i]);
        end
        halt_v = mk(32'h1B090000, 1'b1, 15'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 1'b0);
        apply("stop_halt0", halt_v);
        halt_v.stop = 1'b0;
        apply("stop_halt1", halt_v);
        pulse_clear();

        // Unlisted opcode 11111
        tbl.delete();
`ifdef CU_ILLEGAL_TRAP_EN
        push_fetch(32'hF8000000, 1'b0);
        tbl.push_back(mk(32'hF8000000, 1'b0, 15'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(32'hF8000000, 1'b0, 15'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 1'b1));
`else
        push_fetch(32'hF8000000, 1'b1);
        tbl.push_back(mk(32'hF8000000, 1'b0, F0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(32'hF8000000, 1'b0, F1, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 1'b0));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("unlisted[%0d]", i), tbl[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
